// File: rtl/gate_seq_ctrl.sv
// Gate sequencer for the equal-precision frequency/phase meter.
// Define PHASE_CNT_EN to build the q-high (phase) counter cnt_p.
module gate_seq_ctrl #(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ack,
  input  logic             ina,
  input  logic             q,
  output logic             o_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_s,
  output logic [CNT_W-1:0] cnt_p
);

  localparam int KW = $clog2(GATE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [KW-1:0] K_GATE = KW'(GATE_CYCLES);
  localparam logic [KW-1:0] K_ONE = KW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DONE
  } state_t;

  state_t r_state;
  logic r_ina_d;
  logic [KW-1:0] r_k;
  logic [TW-1:0] r_to;

  logic w_rise;
  logic w_tmo;
  logic w_close;
  logic w_sx;
  logic w_ss;
  logic w_sp;
  logic [CNT_W-1:0] w_x_nx;
  logic [CNT_W-1:0] w_s_nx;
  logic [CNT_W-1:0] w_p_nx;
  logic [TW-1:0] w_to_nx;

  assign w_rise  = ina & ~r_ina_d;
  assign w_tmo   = ~w_rise & (r_to == T_LAST);
  assign w_close = w_rise & (r_k > K_GATE);
  assign w_to_nx = w_rise ? '0 : r_to + 1'b1;

  // Saturation flags fire on an increment attempted at all-ones.
  assign w_sx   = w_rise & (cnt_x == C_MAX);
  assign w_x_nx = (w_rise & ~w_sx) ? cnt_x + 1'b1 : cnt_x;
  assign w_ss   = (cnt_s == C_MAX);
  assign w_s_nx = w_ss ? cnt_s : cnt_s + 1'b1;

`ifdef PHASE_CNT_EN
  assign w_sp   = q & (cnt_p == C_MAX);
  assign w_p_nx = (q & ~w_sp) ? cnt_p + 1'b1 : cnt_p;
`else
  logic w_unused_q;
  assign w_unused_q = q;
  assign w_sp   = 1'b0;
  assign w_p_nx = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ina_d <= 1'b0;
      r_k     <= '0;
      r_to    <= '0;
      o_en    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt_x   <= '0;
      cnt_s   <= '0;
      cnt_p   <= '0;
    end else begin
      r_ina_d <= ina;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ARM;
            busy    <= 1'b1;
            err     <= 1'b0;
            cnt_x   <= '0;
            cnt_s   <= '0;
            cnt_p   <= '0;
            r_k     <= '0;
            r_to    <= '0;
          end
        end
        S_ARM: begin
          r_to <= w_to_nx;
          if (w_tmo) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else if (w_rise) begin
            r_state <= S_MEAS;
            o_en    <= 1'b1;
            r_k     <= K_ONE;
          end
        end
        S_MEAS: begin
          r_to <= w_to_nx;
          if (w_tmo) begin
            r_state <= S_DONE;
            o_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt_s <= w_s_nx;
            cnt_x <= w_x_nx;
            cnt_p <= w_p_nx;
            if (w_ss | w_sx | w_sp) err <= 1'b1;
            if (r_k <= K_GATE) r_k <= r_k + 1'b1;
            if (w_close) begin
              r_state <= S_DONE;
              o_en    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            r_state <= S_IDLE;
            done    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: a 32-bit and a 6-bit instance share stimulus.
// Vector table of periodic/timeout runs plus handshake and reset sequences.
module tb_gate_seq_ctrl;

  localparam int G = 100;
  localparam int T = 1000;
`ifdef PHASE_CNT_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic ina = 1'b0;
  logic q = 1'b0;
  logic o_en, busy, done, err;
  logic [31:0] cnt_x, cnt_s, cnt_p;
  logic s_en, s_busy, s_done, s_err;
  logic [5:0] s_x, s_s, s_p;

  gate_seq_ctrl #(
    .GATE_CYCLES(G), .TIMEOUT_CYCLES(T), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack),
    .ina(ina), .q(q), .o_en(o_en), .busy(busy),
    .done(done), .err(err),
    .cnt_x(cnt_x), .cnt_s(cnt_s), .cnt_p(cnt_p)
  );

  gate_seq_ctrl #(
    .GATE_CYCLES(G), .TIMEOUT_CYCLES(T), .CNT_W(6)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack),
    .ina(ina), .q(q), .o_en(s_en), .busy(s_busy),
    .done(s_done), .err(s_err),
    .cnt_x(s_x), .cnt_s(s_s), .cnt_p(s_p)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot = 0;
  int g_per = 0;
  int g_hi = 0;
  int g_qhi = 0;
  int g_ph = 0;

  // Periodic ina/q generator sharing one phase counter.
  always @(negedge clk) begin
    if (g_ph >= g_per) g_ph = 0;
    if (g_per == 0) begin
      ina = 1'b0;
      q = 1'b0;
    end else begin
      ina = (g_ph < g_hi);
      q = (g_ph < g_qhi);
      g_ph++;
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int en);
    cyc = 0;
    en = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (o_en) en++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input int per, input int hi, input int qhi,
                     output int cyc, output int en);
    g_per = per;
    g_hi = hi;
    g_qhi = qhi;
    repeat (3) @(negedge clk);
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_done(cyc, en);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    string nm;
    int per;
    int hi;
    int qhi;
    int s;
    int x;
    int p;
    int e;
    int en;
    int lat;
    int ss;
    int sx;
    int sp;
  } vec_t;

  initial begin
    vec_t v[7];
    int cyc;
    int en;
    v[0] = '{"p10", 10, 5, 4, 110, 11, 44, 0, 110, -1, 63, 11, 44};
    v[1] = '{"p7", 7, 3, 2, 105, 15, 30, 0, 105, -1, 63, 15, 30};
    v[2] = '{"p25", 25, 10, 25, 125, 5, 125, 0, 125, -1, 63, 5, 63};
    v[3] = '{"p101", 101, 50, 0, 101, 1, 0, 0, 101, -1, 63, 1, 0};
    v[4] = '{"p100", 100, 1, 0, 200, 2, 0, 0, 200, -1, 63, 2, 0};
    v[5] = '{"p2", 2, 1, 1, 102, 51, 51, 0, 102, -1, 63, 51, 51};
    v[6] = '{"tmo", 0, 0, 0, 0, 0, 0, 1, 0, 1000, 0, 0, 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst o_en", o_en, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst cnt_s", cnt_s, 0);
    chk("rst cnt_x", cnt_x, 0);
    chk("rst cnt_p", cnt_p, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run(v[i].per, v[i].hi, v[i].qhi, cyc, en);
      chk({v[i].nm, " cnt_s"}, cnt_s, v[i].s);
      chk({v[i].nm, " cnt_x"}, cnt_x, v[i].x);
      chk({v[i].nm, " cnt_p"}, cnt_p, PH ? v[i].p : 0);
      chk({v[i].nm, " err"}, err, v[i].e);
      chk({v[i].nm, " en_cycles"}, en, v[i].en);
      chk({v[i].nm, " o_en_at_done"}, o_en, 0);
      if (v[i].lat >= 0) chk({v[i].nm, " latency"}, cyc, v[i].lat);
      chk({v[i].nm, " sat done"}, s_done, 1);
      chk({v[i].nm, " sat cnt_s"}, s_s, v[i].ss);
      chk({v[i].nm, " sat cnt_x"}, s_x, v[i].sx);
      chk({v[i].nm, " sat cnt_p"}, s_p, PH ? v[i].sp : 0);
      chk({v[i].nm, " sat err"}, s_err, 1);
      do_ack();
    end

    g_per = 10;
    g_hi = 5;
    g_qhi = 4;
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (40) @(negedge clk);
    chk("hs in_measure", o_en, 1);
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    wait_done(cyc, en);
    chk("hs cnt_s", cnt_s, 110);
    chk("hs cnt_x", cnt_x, 11);
    pulse_start();
    chk("hs done_held", done, 1);
    chk("hs busy_in_done", busy, 0);
    chk("hs cnt_s_held", cnt_s, 110);
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    chk("hs both done", done, 0);
    chk("hs both busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("hs no_restart", busy, 0);
    run(10, 5, 4, cyc, en);
    chk("hs rerun cnt_s", cnt_s, 110);
    chk("hs rerun en", en, 110);
    do_ack();

    pulse_start();
    repeat (40) @(negedge clk);
    chk("rm in_measure", o_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm o_en", o_en, 0);
    chk("rm busy", busy, 0);
    chk("rm done", done, 0);
    chk("rm cnt_s", cnt_s, 0);
    chk("rm cnt_x", cnt_x, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(10, 5, 4, cyc, en);
    chk("rm rerun cnt_s", cnt_s, 110);
    chk("rm rerun cnt_x", cnt_x, 11);
    chk("rm rerun err", err, 0);
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Measurement sequencer for the equal-precision frequency/phase meter. On a start request it opens a preset gate, aligns the actual counting gate to rising edges of test signal a, and counts three quantities over that gate: test-signal periods, reference clock cycles, and XOR-high cycles. It drives the gate-enable into the signal buffer/XOR stage, reads back the buffered signal a and the XOR output, and hands results to the host side with a done/ack handshake.

## Interface
- GATE_CYCLES, 50_000_000: preset gate length in clk cycles (≥1)
- TIMEOUT_CYCLES, 100_000_000: maximum clk cycles without a rising edge of ina before abort (≥2)
- CNT_W, 32: width of every result counter
- clk  in  1  driving clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  measurement request; single-cycle pulse, accepted only in IDLE
- ack  in  1  result acknowledge; accepted only in DONE
- ina  in  1  buffered test signal a, already synchronous to clk
- q  in  1  registered XOR of test signals, synchronous to clk
- o_en  out  1  actual gate; drives the buffer-stage gate input
- busy  out  1  high in ARM and MEASURE
- done  out  1  results valid; held until ack
- err  out  1  valid with done; timeout or counter saturation occurred
- cnt_x  out  CNT_W  rising edges of ina counted in gate (whole input periods)
- cnt_s  out  CNT_W  clk cycles in gate
- cnt_p  out  CNT_W  clk cycles in gate with q high

## Operation
- Edge detect: ina_d <= ina; rise = ina & ~ina_d. ina_d resets to 0.
- States: IDLE, ARM, MEASURE, DONE.
- IDLE: start=1 → ARM; cnt_x/cnt_s/cnt_p, err, gate timer and timeout counter cleared in the same cycle.
- ARM (preset gate open, waiting for alignment): rise → MEASURE. The opening edge is not counted.
- MEASURE: o_en=1. Cycle index k starts at 1 in the first MEASURE cycle. Every cycle: cnt_s+1; cnt_x+1 if rise; cnt_p+1 if q. The gate closes on the first rise with k > GATE_CYCLES; that cycle is counted, then → DONE.
- Timeout counter: clears on every rise and on entry to ARM, and increments every cycle in ARM/MEASURE. On reaching TIMEOUT_CYCLES: → DONE, err=1, counters frozen at their current values.
- Counters saturate at all-ones. The first saturation sets err; the measurement still closes normally.
- DONE: done=1. Outputs stay stable. ack=1 → IDLE. start is ignored.
- start in ARM, MEASURE or DONE is ignored. ack outside DONE is ignored.
- start and ack in the same cycle: only the input legal in the current state acts.

## Timing
- All outputs are registered. Reset values: o_en=0, busy=0, done=0, err=0, all counters 0, state=IDLE.
- start seen at edge n → busy=1 at n+1.
- rise seen in ARM at edge m → o_en=1 from m+1.
- Closing rise at edge c → o_en=0, busy=0, done=1 from c+1, with final counts visible in the same cycle.
- ack at edge d → done=0 at d+1. The next start is accepted from d+1.
- Periodic ina with period P and GATE_CYCLES=G: cnt_s = P·ceil((G+1)/P) and cnt_x = cnt_s/P.
- rst_n low at any clock edge → reset values at the next cycle, including mid-MEASURE. No partial result is reported.

## Configuration
- PHASE_CNT_EN defined: the cnt_p counter is built as described.
- PHASE_CNT_EN undefined: the cnt_p logic is removed, cnt_p is tied to 0, q is unused, and saturation err considers only cnt_x/cnt_s.

## Test plan
- Frequency: GATE_CYCLES=100, ina period 10 (5 high/5 low), start → done with cnt_s=110, cnt_x=11, err=0. o_en is high for exactly 110 cycles.
- Phase (PHASE_CNT_EN): same stimulus, q high 4 of every 10 cycles → cnt_p=44. Build without the macro → cnt_p=0.
- Timeout: TIMEOUT_CYCLES=1000, ina held 0 → done exactly 1000 cycles after entering ARM, err=1, cnt_x=0, o_en never high.
- Handshake: start pulses during MEASURE and DONE → no restart. Simultaneous start+ack in DONE → IDLE, no new measurement. A start after that → normal run.
- Reset mid-op: rst_n low during MEASURE → next cycle o_en=0, busy=0, done=0, counters 0. A new start yields correct results.
- Saturation: CNT_W=6, GATE_CYCLES=100, ina period 10 → cnt_s=63, err=1, done asserted at closing edge.
